vga_frame_scheduler: RTL and testbench

- Sequences a full screen redraw once per frame.
- Each frame it first runs the map display controller over the 21x21 tile grid, then grants the single VGA adapter port to character sprite drawers one at a time: Pac-Man, then ghosts.
- It owns the only connection to the VGA adapter's plot/x/y/color inputs and muxes the active source onto it.

---
 rtl/vga_frame_scheduler.sv | 258 +++++++++++++++++++++++++
 tb/tb_vga_frame_scheduler.sv | 305 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vga_frame_scheduler.sv
// vga_frame_scheduler: once per frame, runs the map controller over the tile grid. It then hands
// the single VGA adapter port to each requesting sprite drawer in turn, round-robin. The adapter
// inputs are driven from a registered mux over the active source.
module vga_frame_scheduler #(
  parameter int unsigned NUM_REQ      = 5,
  parameter int unsigned FRAME_CYCLES = 833333,
  parameter int unsigned SPR_TIMEOUT  = 1024
) (
  input  logic                   i_clock_50,
  input  logic                   i_reset,
  output logic                   o_map_en,
  output logic                   o_map_reset,
  input  logic                   i_map_done,
  input  logic                   i_map_plot,
  input  logic [7:0]             i_map_x,
  input  logic [6:0]             i_map_y,
  input  logic [2:0]             i_map_color,
  input  logic [NUM_REQ-1:0]     i_req,
  input  logic [NUM_REQ-1:0]     i_done,
  output logic [NUM_REQ-1:0]     o_grant,
  input  logic [NUM_REQ-1:0]     i_spr_plot,
  input  logic [8*NUM_REQ-1:0]   i_spr_x,
  input  logic [7*NUM_REQ-1:0]   i_spr_y,
  input  logic [3*NUM_REQ-1:0]   i_spr_color,
  output logic                   o_vga_plot,
  output logic [7:0]             o_vga_x,
  output logic [6:0]             o_vga_y,
  output logic [2:0]             o_vga_color,
  output logic                   o_frame_start,
  output logic                   o_busy,
  output logic                   o_overrun,
  output logic                   o_timeout_err
);

  localparam int unsigned IdxW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int unsigned FcW  = (FRAME_CYCLES > 1) ? $clog2(FRAME_CYCLES) : 1;
  localparam int unsigned WdW  = (SPR_TIMEOUT > 1) ? $clog2(SPR_TIMEOUT) : 1;

  localparam logic [FcW-1:0]  FcLast  = FcW'(FRAME_CYCLES - 1);
  localparam logic [WdW-1:0]  WdLast  = WdW'(SPR_TIMEOUT - 1);
  localparam logic [IdxW-1:0] IdxLast = IdxW'(NUM_REQ - 1);

  typedef enum logic [2:0] {
    StIdle,
    StMapRst,
    StMapDraw,
    StArb,
    StSprite
  } state_e;

  state_e              r_state;
  logic [FcW-1:0]      r_frame_cnt;
  logic [WdW-1:0]      r_wdog;
  logic [NUM_REQ-1:0]  r_served;
  logic [IdxW-1:0]     r_ptr;
  logic [IdxW-1:0]     r_gidx;
  logic [NUM_REQ-1:0]  r_grant;
  logic                r_map_en;
  logic                r_map_reset;
  logic                r_frame_start;
  logic                r_busy;
  logic                r_overrun;
  logic                r_timeout_err;
  logic                r_vga_plot;
  logic [7:0]          r_vga_x;
  logic [6:0]          r_vga_y;
  logic [2:0]          r_vga_color;

  logic                w_tick;
  logic [NUM_REQ-1:0]  w_pend;
  logic                w_arb_found;
  logic [IdxW-1:0]     w_arb_idx;
  logic [NUM_REQ-1:0]  w_arb_onehot;
  int                  w_scan;
  logic                w_done_g;
  logic                w_spr_plot;
  logic [7:0]          w_spr_x;
  logic [6:0]          w_spr_y;
  logic [2:0]          w_spr_color;
  logic                w_wd_expired;
  logic                w_spr_exit;
  logic [IdxW-1:0]     w_ptr_next;

  assign w_tick       = (r_frame_cnt == FcLast);
  assign w_pend       = i_req & ~r_served;
  assign w_wd_expired = (r_wdog == WdLast);
  assign w_spr_exit   = (r_state == StSprite) && (w_done_g || w_wd_expired);
  assign w_ptr_next   = (r_gidx == IdxLast) ? '0 : r_gidx + IdxW'(1);

  // Free-running frame counter; the tick fires on the cycle the counter sits at its last value.
  always_ff @(posedge i_clock_50) begin
    if (!i_reset) begin
      r_frame_cnt <= '0;
    end else if (w_tick) begin
      r_frame_cnt <= '0;
    end else begin
      r_frame_cnt <= r_frame_cnt + FcW'(1);
    end
  end

  // Select the granted drawer's pixel stream and completion pulse.
  always_comb begin
    w_done_g    = 1'b0;
    w_spr_plot  = 1'b0;
    w_spr_x     = '0;
    w_spr_y     = '0;
    w_spr_color = '0;
    for (int i = 0; i < int'(NUM_REQ); i++) begin
      if (r_gidx == IdxW'(i)) begin
        w_done_g    = i_done[i];
        w_spr_plot  = i_spr_plot[i];
        w_spr_x     = i_spr_x[8*i +: 8];
        w_spr_y     = i_spr_y[7*i +: 7];
        w_spr_color = i_spr_color[3*i +: 3];
      end
    end
  end

  // Round-robin search over pending (requesting and not yet served) drawers, from the pointer.
  always_comb begin
    w_arb_found = 1'b0;
    w_arb_idx   = '0;
    w_scan      = 0;
    for (int k = 0; k < int'(NUM_REQ); k++) begin
      w_scan = int'(r_ptr) + k;
      if (w_scan >= int'(NUM_REQ)) begin
        w_scan = w_scan - int'(NUM_REQ);
      end
      if (!w_arb_found && w_pend[IdxW'(w_scan)]) begin
        w_arb_found = 1'b1;
        w_arb_idx   = IdxW'(w_scan);
      end
    end
  end

  // One-hot grant vector for the arbitration winner.
  always_comb begin
    w_arb_onehot = '0;
    for (int i = 0; i < int'(NUM_REQ); i++) begin
      w_arb_onehot[i] = (w_arb_idx == IdxW'(i));
    end
  end

  // Frame sequencing FSM with registered control outputs.
  always_ff @(posedge i_clock_50) begin
    if (!i_reset) begin
      r_state       <= StIdle;
      r_wdog        <= '0;
      r_served      <= '0;
      r_ptr         <= '0;
      r_gidx        <= '0;
      r_grant       <= '0;
      r_map_en      <= 1'b0;
      r_map_reset   <= 1'b0;
      r_frame_start <= 1'b0;
      r_busy        <= 1'b0;
      r_overrun     <= 1'b0;
      r_timeout_err <= 1'b0;
    end else begin
      r_frame_start <= 1'b0;
      r_map_reset   <= 1'b0;
      // A tick that lands mid-frame is dropped; only the sticky flag records it.
      if (w_tick && (r_state != StIdle)) begin
        r_overrun <= 1'b1;
      end
      case (r_state)
        StIdle: begin
          if (w_tick) begin
            r_state       <= StMapRst;
            r_frame_start <= 1'b1;
            r_map_reset   <= 1'b1;
            r_busy        <= 1'b1;
          end
        end
        StMapRst: begin
          r_state  <= StMapDraw;
          r_map_en <= 1'b1;
        end
        StMapDraw: begin
          if (i_map_done) begin
            r_map_en <= 1'b0;
            r_served <= '0;
            r_state  <= StArb;
          end
        end
        StArb: begin
          if (w_arb_found) begin
            r_gidx  <= w_arb_idx;
            r_grant <= w_arb_onehot;
            r_wdog  <= '0;
            r_state <= StSprite;
          end else begin
            r_state <= StIdle;
            r_busy  <= 1'b0;
          end
        end
        StSprite: begin
          r_wdog <= r_wdog + WdW'(1);
          if (w_spr_exit) begin
            r_grant          <= '0;
            r_served[r_gidx] <= 1'b1;
            r_ptr            <= w_ptr_next;
            r_state          <= StArb;
            // A done arriving on the watchdog's last cycle still counts as a clean finish.
            if (!w_done_g) begin
              r_timeout_err <= 1'b1;
            end
          end
        end
        default: begin
          r_state <= StIdle;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  // Registered VGA mux; plot is suppressed on the edge a source loses the port.
  always_ff @(posedge i_clock_50) begin
    if (!i_reset) begin
      r_vga_plot  <= 1'b0;
      r_vga_x     <= '0;
      r_vga_y     <= '0;
      r_vga_color <= '0;
    end else begin
      case (r_state)
        StMapDraw: begin
          r_vga_plot  <= i_map_plot && !i_map_done;
          r_vga_x     <= i_map_x;
          r_vga_y     <= i_map_y;
          r_vga_color <= i_map_color;
        end
        StSprite: begin
          r_vga_plot  <= w_spr_plot && !w_spr_exit;
          r_vga_x     <= w_spr_x;
          r_vga_y     <= w_spr_y;
          r_vga_color <= w_spr_color;
        end
        default: begin
          r_vga_plot <= 1'b0;
        end
      endcase
    end
  end

  assign o_map_en      = r_map_en;
  assign o_map_reset   = r_map_reset;
  assign o_grant       = r_grant;
  assign o_vga_plot    = r_vga_plot;
  assign o_vga_x       = r_vga_x;
  assign o_vga_y       = r_vga_y;
  assign o_vga_color   = r_vga_color;
  assign o_frame_start = r_frame_start;
  assign o_busy        = r_busy;
  assign o_overrun     = r_overrun;
  assign o_timeout_err = r_timeout_err;

endmodule

// File: tb/tb_vga_frame_scheduler.sv
// Directed, table-driven bench for vga_frame_scheduler with a short frame and watchdog.
module tb_vga_frame_scheduler;

  localparam int unsigned NumReq  = 5;
  localparam int unsigned FrameCy = 100;
  localparam int unsigned SprTo   = 16;

  logic                  clk;
  logic                  rst_n;
  logic                  map_en;
  logic                  map_reset;
  logic                  map_done;
  logic                  map_plot;
  logic [7:0]            map_x;
  logic [6:0]            map_y;
  logic [2:0]            map_color;
  logic [NumReq-1:0]     req;
  logic [NumReq-1:0]     done;
  logic [NumReq-1:0]     grant;
  logic [NumReq-1:0]     spr_plot;
  logic [8*NumReq-1:0]   spr_x;
  logic [7*NumReq-1:0]   spr_y;
  logic [3*NumReq-1:0]   spr_color;
  logic                  vga_plot;
  logic [7:0]            vga_x;
  logic [6:0]            vga_y;
  logic [2:0]            vga_color;
  logic                  frame_start;
  logic                  busy;
  logic                  overrun;
  logic                  timeout_err;

  int n_checks = 0;
  int n_pass   = 0;

  vga_frame_scheduler #(
    .NUM_REQ      (NumReq),
    .FRAME_CYCLES (FrameCy),
    .SPR_TIMEOUT  (SprTo)
  ) dut (
    .i_clock_50    (clk),
    .i_reset       (rst_n),
    .o_map_en      (map_en),
    .o_map_reset   (map_reset),
    .i_map_done    (map_done),
    .i_map_plot    (map_plot),
    .i_map_x       (map_x),
    .i_map_y       (map_y),
    .i_map_color   (map_color),
    .i_req         (req),
    .i_done        (done),
    .o_grant       (grant),
    .i_spr_plot    (spr_plot),
    .i_spr_x       (spr_x),
    .i_spr_y       (spr_y),
    .i_spr_color   (spr_color),
    .o_vga_plot    (vga_plot),
    .o_vga_x       (vga_x),
    .o_vga_y       (vga_y),
    .o_vga_color   (vga_color),
    .o_frame_start (frame_start),
    .o_busy        (busy),
    .o_overrun     (overrun),
    .o_timeout_err (timeout_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Hard stop in case a sequence stalls.
  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish within time limit");
    $fatal(1);
  end

  typedef struct {
    logic [4:0] plot;
    logic [4:0] dn;
    logic [4:0] exp_grant;
    logic       exp_vplot;
    logic [7:0] exp_x;
    logic [6:0] exp_y;
    logic [2:0] exp_color;
    logic       exp_busy;
  } vec_t;

  vec_t vecs [11];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Step edges until frame_start is seen (bounded); n = edges taken.
  task automatic wait_frame(output int n, input int limit);
    n = 0;
    do begin
      tick();
      n++;
    end while (!frame_start && n < limit);
    check("frame_start_seen", 32'(frame_start), 32'd1);
  endtask

  int n;
  int bad;
  int cnt;
  int starts;

  initial begin
    // Sprite phase of frame 2: req=10110, pointer 0. Row 0 is applied in ARB.
    //            plot      done      grant     vp    x      y      col   busy
    vecs[0]  = '{5'b00000, 5'b00000, 5'b00010, 1'b0, 8'd0,  7'd0,  3'd0, 1'b1};
    vecs[1]  = '{5'b01010, 5'b00000, 5'b00010, 1'b1, 8'd50, 7'd30, 3'd6, 1'b1};
    vecs[2]  = '{5'b00000, 5'b01000, 5'b00010, 1'b0, 8'd50, 7'd30, 3'd6, 1'b1};
    vecs[3]  = '{5'b00010, 5'b00010, 5'b00000, 1'b0, 8'd50, 7'd30, 3'd6, 1'b1};
    vecs[4]  = '{5'b00000, 5'b00000, 5'b00100, 1'b0, 8'd50, 7'd30, 3'd6, 1'b1};
    vecs[5]  = '{5'b00100, 5'b00000, 5'b00100, 1'b1, 8'd60, 7'd31, 3'd2, 1'b1};
    vecs[6]  = '{5'b00000, 5'b00100, 5'b00000, 1'b0, 8'd60, 7'd31, 3'd2, 1'b1};
    vecs[7]  = '{5'b00000, 5'b00000, 5'b10000, 1'b0, 8'd60, 7'd31, 3'd2, 1'b1};
    vecs[8]  = '{5'b10000, 5'b00000, 5'b10000, 1'b1, 8'd70, 7'd34, 3'd3, 1'b1};
    vecs[9]  = '{5'b00000, 5'b10000, 5'b00000, 1'b0, 8'd70, 7'd34, 3'd3, 1'b1};
    vecs[10] = '{5'b00000, 5'b00000, 5'b00000, 1'b0, 8'd70, 7'd34, 3'd3, 1'b0};

    rst_n     = 1'b0;
    map_done  = 1'b0;
    map_plot  = 1'b0;
    map_x     = '0;
    map_y     = '0;
    map_color = '0;
    req       = '0;
    done      = '0;
    spr_plot  = '0;
    spr_x     = {8'd70, 8'd99, 8'd60, 8'd50, 8'd0};
    spr_y     = {7'd34, 7'd33, 7'd31, 7'd30, 7'd0};
    spr_color = {3'd3, 3'd7, 3'd2, 3'd6, 3'd0};

    repeat (3) tick();
    check("rst grant", 32'(grant), 32'd0);
    check("rst map_en", 32'(map_en), 32'd0);
    check("rst map_reset", 32'(map_reset), 32'd0);
    check("rst vga_plot", 32'(vga_plot), 32'd0);
    check("rst frame_start", 32'(frame_start), 32'd0);
    check("rst busy", 32'(busy), 32'd0);
    check("rst overrun", 32'(overrun), 32'd0);
    check("rst timeout_err", 32'(timeout_err), 32'd0);

    // Frame 1: counter hits 99 after 99 edges; frame_start registers on edge 100.
    rst_n = 1'b1;
    wait_frame(n, 200);
    check("t1 frame_start latency", 32'(n), 32'(FrameCy));
    check("t1 map_reset", 32'(map_reset), 32'd1);
    check("t1 busy", 32'(busy), 32'd1);
    check("t1 map_en in MAP_RST", 32'(map_en), 32'd0);
    tick();
    check("t1 map_reset one cycle", 32'(map_reset), 32'd0);
    check("t1 frame_start one cycle", 32'(frame_start), 32'd0);
    check("t1 map_en", 32'(map_en), 32'd1);
    map_plot  = 1'b1;
    map_x     = 8'd10;
    map_y     = 7'd20;
    map_color = 3'd5;
    tick();
    check("t1 map vga_plot", 32'(vga_plot), 32'd1);
    check("t1 map vga_x", 32'(vga_x), 32'd10);
    check("t1 map vga_y", 32'(vga_y), 32'd20);
    check("t1 map vga_color", 32'(vga_color), 32'd5);
    map_plot  = 1'b0;
    map_x     = '0;
    map_y     = '0;
    map_color = '0;
    bad = 0;
    repeat (48) begin
      tick();
      if (grant !== '0 || map_en !== 1'b1) bad++;
    end
    check("t1 map_draw hold", 32'(bad), 32'd0);
    map_done = 1'b1;
    tick();
    map_done = 1'b0;
    check("t1 map_en drop", 32'(map_en), 32'd0);
    check("t1 vga_plot in ARB", 32'(vga_plot), 32'd0);
    tick();
    check("t1 idle busy", 32'(busy), 32'd0);
    check("t1 idle grant", 32'(grant), 32'd0);

    // Frame 2: round-robin order and VGA mux, driven from the vector table.
    req = 5'b10110;
    wait_frame(n, 200);
    tick();
    map_done = 1'b1;
    tick();
    map_done = 1'b0;
    for (int i = 0; i < 11; i++) begin
      spr_plot = vecs[i].plot;
      done     = vecs[i].dn;
      tick();
      check($sformatf("t2 row%0d grant", i), 32'(grant), 32'(vecs[i].exp_grant));
      check($sformatf("t2 row%0d vga_plot", i), 32'(vga_plot), 32'(vecs[i].exp_vplot));
      check($sformatf("t2 row%0d vga_x", i), 32'(vga_x), 32'(vecs[i].exp_x));
      check($sformatf("t2 row%0d vga_y", i), 32'(vga_y), 32'(vecs[i].exp_y));
      check($sformatf("t2 row%0d vga_color", i), 32'(vga_color), 32'(vecs[i].exp_color));
      check($sformatf("t2 row%0d busy", i), 32'(busy), 32'(vecs[i].exp_busy));
    end
    spr_plot = '0;
    done     = '0;

    // Frame 3: drawer 2 never finishes; watchdog revokes after SprTo cycles. Pointer is back at 0.
    req = 5'b01100;
    wait_frame(n, 200);
    tick();
    map_done = 1'b1;
    tick();
    map_done = 1'b0;
    tick();
    check("t4 first grant", 32'(grant), 32'b00100);
    cnt = 0;
    while (grant === 5'b00100 && cnt < 40) begin
      cnt++;
      tick();
    end
    check("t4 grant length", 32'(cnt), 32'(SprTo));
    check("t4 grant dropped", 32'(grant), 32'd0);
    check("t4 timeout_err", 32'(timeout_err), 32'd1);
    tick();
    check("t4 next grant", 32'(grant), 32'b01000);
    done = 5'b01000;
    tick();
    done = '0;
    check("t4 grant3 released", 32'(grant), 32'd0);
    tick();
    check("t4 idle busy", 32'(busy), 32'd0);
    check("t4 timeout_err sticky", 32'(timeout_err), 32'd1);

    // Frame 4: map_done withheld past the next tick.
    req = '0;
    wait_frame(n, 200);
    check("t5 overrun clear at start", 32'(overrun), 32'd0);
    starts = 0;
    repeat (120) begin
      tick();
      if (frame_start) starts++;
    end
    check("t5 no second frame_start", 32'(starts), 32'd0);
    check("t5 overrun", 32'(overrun), 32'd1);
    check("t5 still busy", 32'(busy), 32'd1);
    check("t5 still map_en", 32'(map_en), 32'd1);
    map_done = 1'b1;
    tick();
    map_done = 1'b0;
    check("t5 map_en drop", 32'(map_en), 32'd0);
    tick();
    check("t5 idle busy", 32'(busy), 32'd0);
    check("t5 overrun sticky", 32'(overrun), 32'd1);

    // Frame 5: reset mid-SPRITE.
    req = 5'b00001;
    wait_frame(n, 200);
    tick();
    map_done = 1'b1;
    tick();
    map_done = 1'b0;
    tick();
    check("t6 grant0", 32'(grant), 32'b00001);
    spr_plot = 5'b00001;
    tick();
    check("t6 vga_plot before reset", 32'(vga_plot), 32'd1);
    rst_n = 1'b0;
    tick();
    check("t6 grant", 32'(grant), 32'd0);
    check("t6 vga_plot", 32'(vga_plot), 32'd0);
    check("t6 busy", 32'(busy), 32'd0);
    check("t6 overrun", 32'(overrun), 32'd0);
    check("t6 timeout_err", 32'(timeout_err), 32'd0);
    check("t6 map_en", 32'(map_en), 32'd0);
    spr_plot = '0;
    req      = '0;

    // Reset on the same edge as a pending tick: reset wins.
    rst_n = 1'b1;
    repeat (FrameCy - 1) tick();
    check("t7 no frame_start yet", 32'(frame_start), 32'd0);
    rst_n = 1'b0;
    tick();
    check("t7 reset beats tick frame_start", 32'(frame_start), 32'd0);
    check("t7 reset beats tick busy", 32'(busy), 32'd0);
    check("t7 reset beats tick map_reset", 32'(map_reset), 32'd0);
    rst_n = 1'b1;
    wait_frame(n, 200);
    check("t7 counter restarted", 32'(n), 32'(FrameCy));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
